// File: rtl/arbitro_serializador.sv
// -----------------------------------------------------------------------------
// arbitro_serializador
//   Round-robin arbiter in front of a single W-bit parallel-to-serial shifter.
//   While idle (OCIOSO) it picks the next requester after the last one served,
//   captures that requester's word and shifts it out LSB first (DESLOCA), one
//   bit per cycle, then returns to idle for one arbitration cycle.
//
// Ports
//   clock         in   1      system clock, all state on posedge
//   reset         in   1      asynchronous, active-low reset
//   pedido        in   N      level request per requester, held until granted
//   dados         in   N*W    requester words, slice i = dados[i*W +: W]
//   concedido     out  N      one-hot grant pulse (first frame cycle), registered
//   saida_serial  out  1      serial data, LSB first
//   saida_valida  out  1      high while saida_serial carries a frame bit
//   fim_quadro    out  1      high during the last bit of a frame
//   id_ativo      out  ID_W   index of the requester owning the current frame
//   ocupado       out  1      high whenever a frame is being shifted out
// -----------------------------------------------------------------------------
module arbitro_serializador #(
    parameter int N    = 4,
    parameter int W    = 6,
    parameter int ID_W = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [N-1:0]      pedido,
    input  logic [N*W-1:0]    dados,
    output logic [N-1:0]      concedido,
    output logic              saida_serial,
    output logic              saida_valida,
    output logic              fim_quadro,
    output logic [ID_W-1:0]   id_ativo,
    output logic              ocupado
);

    localparam int CW = $clog2(W);
    localparam logic [CW-1:0]   C_ULTIMO_BIT = CW'(W - 1);
    localparam logic [ID_W-1:0] C_ID_FINAL   = ID_W'(N - 1);

    typedef enum logic {
        OCIOSO  = 1'b0,
        DESLOCA = 1'b1
    } estado_t;

    estado_t           r_estado;
    logic [W-1:0]      r_desloc;
    logic [CW-1:0]     r_contador;
    logic [ID_W-1:0]   r_ultimo;
    logic [ID_W-1:0]   r_id_ativo;
    logic [N-1:0]      r_concedido;

    logic [W-1:0]      w_palavras [N];
    logic [ID_W-1:0]   w_vencedor;
    logic              w_achou;
    logic [N-1:0]      w_onehot;

    for (genvar g = 0; g < N; g++) begin : g_fatia
        assign w_palavras[g] = dados[g*W +: W];
    end

    // Rotating priority: the search starts one past the last requester served
    // and wraps, so the previous winner has the lowest priority this round.
    always_comb begin
        int v_idx;
        v_idx      = 0;
        w_achou    = 1'b0;
        w_vencedor = '0;
        for (int k = 1; k <= N; k++) begin
            v_idx = (int'(r_ultimo) + k) % N;
            if (!w_achou && pedido[ID_W'(v_idx)]) begin
                w_achou    = 1'b1;
                w_vencedor = ID_W'(v_idx);
            end
        end
    end

    assign w_onehot = N'(1) << w_vencedor;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_estado    <= OCIOSO;
            r_desloc    <= '0;
            r_contador  <= '0;
            r_ultimo    <= C_ID_FINAL;
            r_id_ativo  <= '0;
            r_concedido <= '0;
        end else begin
            case (r_estado)
                OCIOSO: begin
                    r_concedido <= '0;
                    if (w_achou) begin
                        r_desloc    <= w_palavras[w_vencedor];
                        r_concedido <= w_onehot;
                        r_id_ativo  <= w_vencedor;
                        r_ultimo    <= w_vencedor;
                        r_contador  <= C_ULTIMO_BIT;
                        r_estado    <= DESLOCA;
                    end
                end
                DESLOCA: begin
                    // Grant is a single-cycle pulse aligned with bit 0.
                    r_concedido <= '0;
                    r_desloc    <= r_desloc >> 1;
                    if (r_contador == '0) begin
                        r_estado <= OCIOSO;
                    end else begin
                        r_contador <= r_contador - 1'b1;
                    end
                end
                default: r_estado <= OCIOSO;
            endcase
        end
    end

    // Status outputs decode straight from registered state, so an async reset
    // drops them in the same instant without waiting for a clock edge.
    assign ocupado      = (r_estado == DESLOCA);
    assign saida_valida = (r_estado == DESLOCA);
    assign saida_serial = (r_estado == DESLOCA) && r_desloc[0];
    assign fim_quadro   = (r_estado == DESLOCA) && (r_contador == '0);
    assign concedido    = r_concedido;
    assign id_ativo     = r_id_ativo;

endmodule
